// File: rtl/load_extend_ctrl.sv
// MEM-stage load sequencer: issues a word-aligned read, waits a fixed latency,
// then lane-selects and sign/zero-extends the result behind a valid/ready handshake.
module load_extend_ctrl #(
    parameter int unsigned DATA_BITS   = 32,
    parameter int unsigned ADDR_BITS   = 32,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    output logic                 mem_req,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [DATA_BITS-1:0] mem_rdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_BITS-1:0] resp_data,
    output logic                 resp_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             addr_lo_q, addr_lo_d;
    logic [1:0]             size_q, size_d;
    logic                   unsigned_q, unsigned_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   resp_data_q, resp_data_d;
    logic                   resp_err_q, resp_err_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;

    logic                   req_err;
    logic                   accept;
    logic [7:0]             byte_sel;
    logic [15:0]            half_sel;
    logic                   sign_fill;
    logic [DATA_BITS-1:0]   extended;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_lo_q   <= '0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_lo_q   <= addr_lo_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    always_comb begin
        req_err = 1'b0;
        unique case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    assign accept = (state_q == IDLE) && req_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (req_valid) state_d = req_err ? RESP : ISSUE;
            ISSUE: state_d = WAIT;
            WAIT:  if (cnt_q == '0) state_d = RESP;
            RESP:  if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Little-endian lane select on the latched low address bits.
    always_comb begin
        byte_sel  = mem_rdata[{addr_lo_q, 3'b000} +: 8];
        half_sel  = mem_rdata[{addr_lo_q[1], 4'b0000} +: 16];
        sign_fill = 1'b0;
        extended  = mem_rdata;
        unique case (size_q)
            2'b00: begin
                sign_fill = ~unsigned_q & byte_sel[7];
                extended  = {{(DATA_BITS-8){sign_fill}}, byte_sel};
            end
            2'b01: begin
                sign_fill = ~unsigned_q & half_sel[15];
                extended  = {{(DATA_BITS-16){sign_fill}}, half_sel};
            end
            default: extended = mem_rdata;
        endcase
    end

    always_comb begin
        addr_lo_d   = addr_lo_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        mem_addr_d  = mem_addr_q;
        if (accept) begin
            addr_lo_d  = req_addr[1:0];
            size_d     = req_size;
            unsigned_d = req_unsigned;
            if (req_err) begin
                resp_data_d = '0;
                resp_err_d  = 1'b1;
            end else begin
                mem_addr_d = {req_addr[ADDR_BITS-1:2], 2'b00};
            end
        end
        if (state_q == ISSUE) begin
            cnt_d = 4'(MEM_LATENCY - 1);
        end
        if (state_q == WAIT) begin
            if (cnt_q == '0) begin
                resp_data_d = extended;
                resp_err_d  = 1'b0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        mem_req    = (state_q == ISSUE);
        resp_valid = (state_q == RESP);
        mem_addr   = mem_addr_q;
        resp_data  = resp_data_q;
        resp_err   = resp_err_q;
    end

endmodule

// File: doc/load_extend_ctrl.md
# load_extend_ctrl

Sequencing controller for the MEM-stage load path. It accepts one load request at a time and issues a word-aligned read to the data memory. It waits a fixed memory latency, then selects the addressed byte, halfword or word and sign- or zero-extends it to DATA_BITS. The result goes back to the pipeline through a valid/ready handshake. Misaligned requests are rejected without a memory access.

## Interface
- DATA_BITS, 32, datapath and memory word width (fixed at 32 for byte-lane decode)
- ADDR_BITS, 32, byte address width
- MEM_LATENCY, 2, cycles from the mem_req cycle to mem_rdata valid; legal range 1..15

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  load request present
- req_ready  out  1  controller can accept a request
- req_addr  in  ADDR_BITS  byte address
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as error)
- req_unsigned  in  1  1 = zero-extend, 0 = sign-extend
- mem_req  out  1  one-cycle read strobe
- mem_addr  out  ADDR_BITS  word-aligned read address, {req_addr[ADDR_BITS-1:2], 2'b00}
- mem_rdata  in  DATA_BITS  read data, valid exactly MEM_LATENCY cycles after mem_req
- resp_valid  out  1  result available
- resp_ready  in  1  pipeline consumes result
- resp_data  out  DATA_BITS  extended load result
- resp_err  out  1  misaligned or reserved-size request; resp_data = 0

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch addr[1:0], size and unsigned.
  - Aligned request → ISSUE.
  - Error request → RESP with resp_err = 1 and no memory access.
- Alignment rules:
  - Byte: always aligned.
  - Half: addr[0] = 0.
  - Word: addr[1:0] = 0.
  - Size 11: error.
- ISSUE: mem_req = 1 for exactly one cycle; mem_addr is driven. Load the latency counter with MEM_LATENCY-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture the extended mem_rdata into resp_data and go to RESP.
  - With MEM_LATENCY = 1, WAIT lasts one cycle.
- Lane select (little-endian):
  - Byte = mem_rdata[8*a+7 : 8*a], where a = addr[1:0].
  - Half = mem_rdata[16*addr[1]+15 : 16*addr[1]].
  - Word = mem_rdata.
- Extension: replicate the selected MSB (signed) or 0 (unsigned) into the upper bits. Word loads pass through unchanged.
- RESP: resp_valid = 1. resp_data and resp_err stay stable until resp_ready. On resp_valid & resp_ready, go to IDLE.
- req_ready = 0 in every state except IDLE. Back-to-back requests are not pipelined.
- mem_addr holds its last value outside ISSUE; its value there is don't-care.

## Timing
- Reset (rst_n low, asynchronous):
  - State = IDLE.
  - req_ready = 1; mem_req = 0; resp_valid = 0; resp_err = 0.
  - resp_data = 0; mem_addr = 0; counter = 0.
- Reset asserted mid-operation aborts the transaction immediately: no response is produced and a pending mem_rdata is ignored.
- All outputs are registered or decoded from state only; no combinational input-to-output paths. In particular, req_ready does not depend on req_valid.
- Aligned request accepted at edge T:
  - mem_req high in cycle T+1.
  - mem_rdata sampled at the end of cycle T+1+MEM_LATENCY.
  - resp_valid first high in cycle T+2+MEM_LATENCY.
  - Latency is MEM_LATENCY+2 cycles, i.e. 4 at the default.
- Error request accepted at T: resp_valid high in cycle T+1; mem_req never asserted.
- resp_ready held low: stay in RESP indefinitely with outputs stable.
- Completion and new request in the same cycle: the request is not accepted. The earliest new acceptance is the cycle after the handshake, when state = IDLE.
- Throughput: one load per MEM_LATENCY+3 cycles with resp_ready tied high.

## Test plan
- Reset then idle: rst_n low for 3 cycles, released → req_ready = 1, mem_req = 0, resp_valid = 0, resp_data = 0.
- Signed byte: addr 0x1003, size 00, unsigned 0, mem_rdata 0x80FF_1234, resp_ready = 1:
  - mem_addr = 0x1000 and mem_req pulses once.
  - resp_data = 0xFFFF_FF80, resp_valid in cycle T+4.
- Unsigned halfword: addr 0x2002, size 01, unsigned 1, mem_rdata 0x9ABC_0011 → resp_data = 0x0000_9ABC. Repeat signed → resp_data = 0xFFFF_9ABC.
- Misaligned: word at addr 0x0002, and halfword at 0x0001:
  - resp_err = 1, resp_data = 0, resp_valid in cycle T+1.
  - mem_req stays 0.
- Backpressure: word load at 0x0004, mem_rdata 0x7FFF_FFFF, resp_ready low for 5 cycles:
  - resp_valid and resp_data = 0x7FFF_FFFF stable throughout; req_ready = 0.
  - req_valid held high is not accepted until the cycle after the handshake.
- Reset mid-WAIT: assert rst_n low one cycle after mem_req → all outputs at reset values asynchronously, no resp_valid afterward. The next load completes normally.
